// File: rtl/impulse_arbiter_if.sv
// impulse_arbiter_if: handshake bundle between the two producers, the
// arbiter and the impulse generator.
//   numero_a/dav_a_/rfd_a : producer A offer (/dav-rfd, dav active low)
//   numero_b/dav_b_/rfd_b : producer B offer
//   numero/dav_/rfd       : downstream offer to the impulse generator
//   grant                 : producer owning the current/last transaction (0=A)
//   busy                  : arbiter not idle
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (producers plus generator)
interface impulse_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] numero_a;
  logic             dav_a_;
  logic             rfd_a;
  logic [WIDTH-1:0] numero_b;
  logic             dav_b_;
  logic             rfd_b;
  logic [WIDTH-1:0] numero;
  logic             dav_;
  logic             rfd;
  logic             grant;
  logic             busy;

  modport slave (
    input  numero_a, dav_a_, numero_b, dav_b_, rfd,
    output rfd_a, rfd_b, numero, dav_, grant, busy
  );

  modport master (
    output numero_a, dav_a_, numero_b, dav_b_, rfd,
    input  rfd_a, rfd_b, numero, dav_, grant, busy
  );
endinterface

// File: rtl/impulse_arbiter.sv
// impulse_arbiter: shares one impulse generator between producers A and B.
// A producer's pulse length is latched on selection, acknowledged, and then
// replayed to the generator. A zero length is acknowledged and dropped.
//
// Ports:
//   clock  - system clock, rising edge
//   reset_ - asynchronous reset, active low
//   bus    - impulse_arbiter_if.slave (producer A/B and generator handshakes,
//            grant, busy)
//
// Build option:
//   IMPULSE_ARBITER_FIXED_PRIO_EN - when defined, A always wins a simultaneous
//   request; otherwise a tie goes to the producer that did not hold grant.
//
// state  | meaning
// S_IDLE | both producers may offer, generator handshake idle
// S_ACK  | winner acknowledged (rfd low), waiting for its dav to rise
// S_WAIT | value held, waiting for the generator to be idle (rfd high)
// S_SEND | value offered to the generator (dav_ low), waiting for rfd low
// S_REL  | dav_ released for one cycle before returning to S_IDLE
module impulse_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset_,
  impulse_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACK  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_REL  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] numero_q, numero_d;
  logic             grant_q, grant_d;
  logic             rfd_a_q, rfd_a_d;
  logic             rfd_b_q, rfd_b_d;
  logic             dav_q, dav_d;
  logic             busy_q, busy_d;

  logic             req_a, req_b;
  logic             pick_b;
  logic             own_dav_high;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    grant_d      = grant_q;
    req_a        = ~bus.dav_a_;
    req_b        = ~bus.dav_b_;
    pick_b       = 1'b0;
    own_dav_high = grant_q ? bus.dav_b_ : bus.dav_a_;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          if (req_a && req_b) begin
`ifdef IMPULSE_ARBITER_FIXED_PRIO_EN
            pick_b = 1'b0;
`else
            // Round-robin: the tie goes to whoever did not win last time.
            pick_b = ~grant_q;
`endif
          end else begin
            pick_b = req_b;
          end
          data_d  = pick_b ? bus.numero_b : bus.numero_a;
          grant_d = pick_b;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (own_dav_high) begin
          state_d = (data_q == '0) ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.rfd) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.rfd) begin
          state_d = S_REL;
        end
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the transition.
    rfd_a_d  = !(state_d == S_ACK && !grant_d);
    rfd_b_d  = !(state_d == S_ACK && grant_d);
    dav_d    = (state_d != S_SEND);
    numero_d = (state_d == S_SEND) ? data_q : numero_q;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      numero_q <= '0;
      grant_q  <= 1'b1;
      rfd_a_q  <= 1'b1;
      rfd_b_q  <= 1'b1;
      dav_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      numero_q <= numero_d;
      grant_q  <= grant_d;
      rfd_a_q  <= rfd_a_d;
      rfd_b_q  <= rfd_b_d;
      dav_q    <= dav_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.rfd_a  = rfd_a_q;
  assign bus.rfd_b  = rfd_b_q;
  assign bus.dav_   = dav_q;
  assign bus.numero = numero_q;
  assign bus.grant  = grant_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_impulse_arbiter.sv
// Directed bench for impulse_arbiter. A generator model accepts downstream
// offers, checks them against a scoreboard of expected (grant, numero)
// pairs and holds rfd low for numero cycles.
module tb_impulse_arbiter;

   typedef struct packed {
      logic       g;
      logic [7:0] n;
   } exp_t;

   logic clock;
   logic reset_;
   int   n_checks = 0;
   int   n_err    = 0;
   bit   gen_stall = 0;
   exp_t sb[$];

   impulse_arbiter_if #(.WIDTH(8)) bus ();

   impulse_arbiter #(.WIDTH(8)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      bit   active;
      exp_t e;
      cnt    = 0;
      active = 0;
      bus.rfd = 1'b1;
      forever begin
         @(posedge clock);
         #2;
         if (!reset_) begin
            bus.rfd = 1'b1;
            active  = 0;
         end else if (active) begin
            if (cnt > 1) begin
               cnt--;
            end else begin
               n_checks++;
               if (bus.dav_ !== 1'b1) begin
                  n_err++;
                  $error("FAIL gen_rel_dav: observed=%0h expected=1", bus.dav_);
               end
               bus.rfd = 1'b1;
               active  = 0;
            end
         end else if (bus.dav_ === 1'b0 && !gen_stall) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $error("FAIL sb_unexpected_send: numero=%0h", bus.numero);
            end else begin
               e = sb.pop_front();
               n_checks++;
               if (bus.numero !== e.n) begin
                  n_err++;
                  $error("FAIL gen_numero: observed=%0h expected=%0h", bus.numero, e.n);
               end
               n_checks++;
               if (bus.grant !== e.g) begin
                  n_err++;
                  $error("FAIL gen_grant: observed=%0h expected=%0h", bus.grant, e.g);
               end
            end
            bus.rfd = 1'b0;
            cnt     = int'(bus.numero);
            active  = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (bus.rfd === 1'b1 && bus.busy === 1'b0) begin
            ok = 1;
            break;
         end
         tick();
      end
      n_checks++;
      if (ok !== 1'b1) begin
         n_err++;
         $error("FAIL wait_idle: rfd=%0h busy=%0h", bus.rfd, bus.busy);
      end
   endtask

   task automatic wait_rfd_low(input bit is_b, input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if ((is_b ? bus.rfd_b : bus.rfd_a) === 1'b0) begin
            ok = 1;
            break;
         end
         tick();
      end
      n_checks++;
      if (ok !== 1'b1) begin
         n_err++;
         $error("FAIL %s: no acknowledge", is_b ? "ack_b" : "ack_a");
      end
   endtask

   task automatic offer(input bit is_b, input logic [7:0] val);
      if (is_b) begin
         bus.numero_b = val;
         bus.dav_b_   = 1'b0;
      end else begin
         bus.numero_a = val;
         bus.dav_a_   = 1'b0;
      end
      tick();
      wait_rfd_low(is_b, 30);
      n_checks++;
      if (bus.grant !== is_b) begin
         n_err++;
         $error("FAIL offer_grant: observed=%0h expected=%0h", bus.grant, is_b);
      end
      if (is_b) begin
         bus.numero_b = ~val;
         bus.dav_b_   = 1'b1;
      end else begin
         bus.numero_a = ~val;
         bus.dav_a_   = 1'b1;
      end
   endtask

   task automatic tie(input logic [7:0] va, input logic [7:0] vb, input bit first_b);
      bus.numero_a = va;
      bus.numero_b = vb;
      bus.dav_a_   = 1'b0;
      bus.dav_b_   = 1'b0;
      sb.push_back('{g: first_b, n: (first_b ? vb : va)});
      sb.push_back('{g: !first_b, n: (first_b ? va : vb)});
      tick();
      n_checks++;
      if (bus.grant !== first_b) begin
         n_err++;
         $error("FAIL tie_grant_first: observed=%0h expected=%0h", bus.grant, first_b);
      end
      n_checks++;
      if (bus.rfd_a !== first_b) begin
         n_err++;
         $error("FAIL tie_rfd_a_first: observed=%0h expected=%0h", bus.rfd_a, first_b);
      end
      n_checks++;
      if (bus.rfd_b !== !first_b) begin
         n_err++;
         $error("FAIL tie_rfd_b_first: observed=%0h expected=%0h", bus.rfd_b, !first_b);
      end
      if (first_b) bus.dav_b_ = 1'b1;
      else         bus.dav_a_ = 1'b1;
      tick();
      n_checks++;
      if ((first_b ? bus.rfd_a : bus.rfd_b) !== 1'b1) begin
         n_err++;
         $error("FAIL tie_loser_rfd_pending");
      end
      wait_rfd_low(!first_b, 40);
      n_checks++;
      if (bus.grant !== !first_b) begin
         n_err++;
         $error("FAIL tie_grant_second: observed=%0h expected=%0h", bus.grant, !first_b);
      end
      if (first_b) bus.dav_a_ = 1'b1;
      else         bus.dav_b_ = 1'b1;
      wait_idle(60);
   endtask

   initial begin
      bit saw_low;
      bit first_b;
      bus.numero_a = '0;
      bus.numero_b = '0;
      bus.dav_a_   = 1'b1;
      bus.dav_b_   = 1'b1;
      reset_       = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.rfd_a !== 1'b1) begin n_err++; $error("FAIL rst_rfd_a: %0h", bus.rfd_a); end
      n_checks++;
      if (bus.rfd_b !== 1'b1) begin n_err++; $error("FAIL rst_rfd_b: %0h", bus.rfd_b); end
      n_checks++;
      if (bus.dav_ !== 1'b1) begin n_err++; $error("FAIL rst_dav: %0h", bus.dav_); end
      n_checks++;
      if (bus.numero !== 8'd0) begin n_err++; $error("FAIL rst_numero: %0h", bus.numero); end
      n_checks++;
      if (bus.grant !== 1'b1) begin n_err++; $error("FAIL rst_grant: %0h", bus.grant); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_err++; $error("FAIL rst_busy: %0h", bus.busy); end
      reset_ = 1'b1;
      tick();

      bus.numero_a = 8'd5;
      bus.dav_a_   = 1'b0;
      sb.push_back('{g: 1'b0, n: 8'd5});
      n_checks++;
      if (bus.rfd_a !== 1'b1) begin n_err++; $error("FAIL t1_rfd_a_before: %0h", bus.rfd_a); end
      tick();
      n_checks++;
      if (bus.rfd_a !== 1'b0) begin n_err++; $error("FAIL t1_rfd_a_ack: %0h", bus.rfd_a); end
      n_checks++;
      if (bus.rfd_b !== 1'b1) begin n_err++; $error("FAIL t1_rfd_b: %0h", bus.rfd_b); end
      n_checks++;
      if (bus.grant !== 1'b0) begin n_err++; $error("FAIL t1_grant: %0h", bus.grant); end
      n_checks++;
      if (bus.busy !== 1'b1) begin n_err++; $error("FAIL t1_busy: %0h", bus.busy); end
      bus.dav_a_   = 1'b1;
      bus.numero_a = 8'd77;
      tick();
      n_checks++;
      if (bus.rfd_a !== 1'b1) begin n_err++; $error("FAIL t1_rfd_a_release: %0h", bus.rfd_a); end
      n_checks++;
      if (bus.dav_ !== 1'b1) begin n_err++; $error("FAIL t1_dav_wait: %0h", bus.dav_); end
      tick();
      n_checks++;
      if (bus.dav_ !== 1'b0) begin n_err++; $error("FAIL t1_dav_send: %0h", bus.dav_); end
      n_checks++;
      if (bus.numero !== 8'd5) begin n_err++; $error("FAIL t1_numero: %0h", bus.numero); end
      tick();
      n_checks++;
      if (bus.dav_ !== 1'b1) begin n_err++; $error("FAIL t1_dav_rel: %0h", bus.dav_); end
      n_checks++;
      if (bus.numero !== 8'd5) begin n_err++; $error("FAIL t1_numero_hold: %0h", bus.numero); end
      tick();
      n_checks++;
      if (bus.busy !== 1'b0) begin n_err++; $error("FAIL t1_busy_idle: %0h", bus.busy); end
      wait_idle(30);

      reset_ = 1'b0;
      tick();
      reset_ = 1'b1;
      tick();
      tie(8'd3, 8'd7, 1'b0);

      bus.numero_a = 8'd0;
      bus.dav_a_   = 1'b0;
      tick();
      n_checks++;
      if (bus.rfd_a !== 1'b0) begin n_err++; $error("FAIL t4_rfd_a_ack: %0h", bus.rfd_a); end
      bus.dav_a_ = 1'b1;
      tick();
      n_checks++;
      if (bus.rfd_a !== 1'b1) begin n_err++; $error("FAIL t4_rfd_a_release: %0h", bus.rfd_a); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_err++; $error("FAIL t4_busy: %0h", bus.busy); end
      saw_low = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.dav_ !== 1'b1) saw_low = 1;
         tick();
      end
      n_checks++;
      if (saw_low !== 1'b0) begin n_err++; $error("FAIL t4_dav_never_low"); end
      n_checks++;
      if (bus.grant !== 1'b0) begin n_err++; $error("FAIL t4_grant: %0h", bus.grant); end

`ifdef IMPULSE_ARBITER_FIXED_PRIO_EN
      first_b = 1'b0;
`else
      first_b = 1'b1;
`endif
      tie(8'd3, 8'd7, first_b);

      sb.push_back('{g: 1'b0, n: 8'd10});
      offer(1'b0, 8'd10);
      saw_low = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.rfd === 1'b0) begin
            saw_low = 1;
            break;
         end
         tick();
      end
      n_checks++;
      if (saw_low !== 1'b1) begin n_err++; $error("FAIL t5_gen_accepted"); end
      sb.push_back('{g: 1'b1, n: 8'd4});
      offer(1'b1, 8'd4);
      tick();
      n_checks++;
      if (bus.rfd !== 1'b0) begin n_err++; $error("FAIL t5_stall_rfd: %0h", bus.rfd); end
      n_checks++;
      if (bus.dav_ !== 1'b1) begin n_err++; $error("FAIL t5_stall_dav: %0h", bus.dav_); end
      n_checks++;
      if (bus.busy !== 1'b1) begin n_err++; $error("FAIL t5_stall_busy: %0h", bus.busy); end
      saw_low = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.rfd === 1'b1) begin
            saw_low = 1;
            break;
         end
         n_checks++;
         if (bus.dav_ !== 1'b1) begin n_err++; $error("FAIL t5_dav_held: %0h", bus.dav_); end
         tick();
      end
      n_checks++;
      if (saw_low !== 1'b1) begin n_err++; $error("FAIL t5_rfd_rose"); end
      n_checks++;
      if (bus.dav_ !== 1'b0) begin n_err++; $error("FAIL t5_dav_first_edge: %0h", bus.dav_); end
      n_checks++;
      if (bus.numero !== 8'd4) begin n_err++; $error("FAIL t5_numero: %0h", bus.numero); end
      wait_idle(40);

      gen_stall = 1;
      offer(1'b0, 8'd6);
      saw_low = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.dav_ === 1'b0) begin
            saw_low = 1;
            break;
         end
         tick();
      end
      n_checks++;
      if (saw_low !== 1'b1) begin n_err++; $error("FAIL t6_in_send"); end
      n_checks++;
      if (bus.numero !== 8'd6) begin n_err++; $error("FAIL t6_numero_send: %0h", bus.numero); end
      reset_ = 1'b0;
      #1;
      n_checks++;
      if (bus.dav_ !== 1'b1) begin n_err++; $error("FAIL t6_async_dav: %0h", bus.dav_); end
      n_checks++;
      if (bus.rfd_a !== 1'b1) begin n_err++; $error("FAIL t6_async_rfd_a: %0h", bus.rfd_a); end
      n_checks++;
      if (bus.rfd_b !== 1'b1) begin n_err++; $error("FAIL t6_async_rfd_b: %0h", bus.rfd_b); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_err++; $error("FAIL t6_async_busy: %0h", bus.busy); end
      n_checks++;
      if (bus.numero !== 8'd0) begin n_err++; $error("FAIL t6_async_numero: %0h", bus.numero); end
      n_checks++;
      if (bus.grant !== 1'b1) begin n_err++; $error("FAIL t6_async_grant: %0h", bus.grant); end
      gen_stall = 0;
      tick();
      reset_ = 1'b1;
      tick();
      sb.push_back('{g: 1'b1, n: 8'd9});
      offer(1'b1, 8'd9);
      wait_idle(40);
      n_checks++;
      if (sb.size() != 0) begin n_err++; $error("FAIL sb_drained: %0d left", sb.size()); end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
